// File: rtl/bonsai_merge_pkg.sv
// Shared constants for the 32-record bitonic merge network: sizes, stage count,
// per-stage compare distances and the pair-index helper used by the generate loops.
package bonsai_merge_pkg;

  localparam int N_HALF   = 16;
  localparam int N_TOTAL  = 32;
  localparam int N_STAGES = 5;

  localparam int DIST_S1 = 16;
  localparam int DIST_S2 = 8;
  localparam int DIST_S3 = 4;
  localparam int DIST_S4 = 2;
  localparam int DIST_S5 = 1;

  function automatic int stage_dist(input int k);
    case (k)
      0:       return DIST_S1;
      1:       return DIST_S2;
      2:       return DIST_S3;
      3:       return DIST_S4;
      default: return DIST_S5;
    endcase
  endfunction

  // Lower index of pair p (0..15) when comparing at distance d inside blocks of 2*d.
  function automatic int pair_lo(input int d, input int p);
    return (p / d) * 2 * d + (p % d);
  endfunction

endpackage

// File: rtl/bitonic_cas.sv
// Combinational compare-and-swap of two records on their low KEY_WIDTH bits.
// Ties keep the original order; payload bits travel with their record.
module bitonic_cas #(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 80
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi
);

  logic swap;

  assign swap = a[KEY_WIDTH-1:0] > b[KEY_WIDTH-1:0];
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/bitonic_merge_net_32.sv
// Five-stage pipelined bitonic merge of two ascending 16-record lists into 32 sorted records.
// Optional macro BITONIC_ASSERT_EN compiles in simulation-only ordering assertions.
module bitonic_merge_net_32
  import bonsai_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 80
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         switch_output,
  input  logic                         stall,
  input  logic [16*DATA_WIDTH-1:0]     top_tuple,
  input  logic [16*DATA_WIDTH-1:0]     i_elems_0,
  input  logic [16*DATA_WIDTH-1:0]     i_elems_1,
  output logic [16*DATA_WIDTH-1:0]     o_elems_0,
  output logic [16*DATA_WIDTH-1:0]     o_elems_1,
  output logic                         o_switch_output,
  output logic                         o_stall,
  output logic [16*DATA_WIDTH-1:0]     o_top_tuple
);

  localparam int LW = N_HALF * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] s_in    [N_TOTAL];
  logic [DATA_WIDTH-1:0] stage_i [N_STAGES][N_TOTAL];
  logic [DATA_WIDTH-1:0] stage_d [N_STAGES][N_TOTAL];
  logic [DATA_WIDTH-1:0] stage_q [N_STAGES][N_TOTAL];
  logic [LW-1:0]         top_q   [N_STAGES];
  logic [N_STAGES-1:0]   stall_q;
  logic [N_STAGES-1:0]   sw_q;

  // List B enters reversed so the 32-entry sequence is bitonic.
  for (genvar i = 0; i < N_HALF; i++) begin : g_in
    assign s_in[i]          = i_elems_0[i*DATA_WIDTH +: DATA_WIDTH];
    assign s_in[N_HALF + i] = i_elems_1[(N_HALF-1-i)*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    localparam int D = stage_dist(k);

    for (genvar i = 0; i < N_TOTAL; i++) begin : g_src
      if (k == 0) begin : g_first
        assign stage_i[k][i] = s_in[i];
      end else begin : g_next
        assign stage_i[k][i] = stage_q[k-1][i];
      end
    end

    for (genvar p = 0; p < N_HALF; p++) begin : g_cas
      localparam int LO = pair_lo(D, p);
      localparam int HI = LO + D;

      bitonic_cas #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEY_WIDTH  (KEY_WIDTH)
      ) u_cas (
        .a  (stage_i[k][LO]),
        .b  (stage_i[k][HI]),
        .lo (stage_d[k][LO]),
        .hi (stage_d[k][HI])
      );
    end
  end

  // No handshake: there is no ready/backpressure, the pipeline shifts every cycle,
  // and stall is only a bubble tag (1 = beat invalid) carried in lockstep with the data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_STAGES; k++) begin
        for (int i = 0; i < N_TOTAL; i++) begin
          stage_q[k][i] <= '0;
        end
        top_q[k] <= '0;
      end
      stall_q <= '1;
      sw_q    <= '0;
    end else begin
      for (int k = 0; k < N_STAGES; k++) begin
        for (int i = 0; i < N_TOTAL; i++) begin
          stage_q[k][i] <= stage_d[k][i];
        end
      end
      top_q[0] <= top_tuple;
      for (int k = 1; k < N_STAGES; k++) begin
        top_q[k] <= top_q[k-1];
      end
      stall_q <= {stall_q[N_STAGES-2:0], stall};
      sw_q    <= {sw_q[N_STAGES-2:0], switch_output};
    end
  end

  for (genvar i = 0; i < N_HALF; i++) begin : g_out
    assign o_elems_0[i*DATA_WIDTH +: DATA_WIDTH] = stage_q[N_STAGES-1][i];
    assign o_elems_1[i*DATA_WIDTH +: DATA_WIDTH] = stage_q[N_STAGES-1][N_HALF + i];
  end

  assign o_top_tuple     = top_q[N_STAGES-1];
  assign o_stall         = stall_q[N_STAGES-1];
  assign o_switch_output = sw_q[N_STAGES-1];

`ifdef BITONIC_ASSERT_EN
  always @(posedge i_clk) begin
    if (i_rst_n) begin
      if (!stall) begin
        for (int i = 0; i < N_HALF - 1; i++) begin
          assert (i_elems_0[i*DATA_WIDTH +: KEY_WIDTH] <= i_elems_0[(i+1)*DATA_WIDTH +: KEY_WIDTH])
            else $error("bitonic_merge_net_32: i_elems_0 out of order at record %0d", i + 1);
          assert (i_elems_1[i*DATA_WIDTH +: KEY_WIDTH] <= i_elems_1[(i+1)*DATA_WIDTH +: KEY_WIDTH])
            else $error("bitonic_merge_net_32: i_elems_1 out of order at record %0d", i + 1);
        end
      end
      if (!o_stall) begin
        for (int i = 0; i < N_TOTAL - 1; i++) begin
          assert (stage_q[N_STAGES-1][i][KEY_WIDTH-1:0] <= stage_q[N_STAGES-1][i+1][KEY_WIDTH-1:0])
            else $error("bitonic_merge_net_32: output out of order at record %0d", i + 1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_bitonic_merge_net_32.sv
// Self-checking bench for bitonic_merge_net_32: directed and random merges scored
// against a sort-based reference with a 5-deep expected-beat queue.
module tb_bitonic_merge_net_32;

  localparam int DW     = 128;
  localparam int KW     = 80;
  localparam int NH     = 16;
  localparam int LW     = NH * DW;
  localparam int LAT    = 5;
  localparam int BEAT_W = 3 * LW + 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          switch_output;
  logic          stall;
  logic [LW-1:0] top_tuple;
  logic [LW-1:0] i_elems_0;
  logic [LW-1:0] i_elems_1;
  logic [LW-1:0] o_elems_0;
  logic [LW-1:0] o_elems_1;
  logic          o_switch_output;
  logic          o_stall;
  logic [LW-1:0] o_top_tuple;

  int total = 0;
  int bad   = 0;

  // Each entry: {stall, switch_output, top_tuple, list B, list A}
  logic [BEAT_W-1:0] exp_q[$];

  bitonic_merge_net_32 #(
    .DATA_WIDTH (DW),
    .KEY_WIDTH  (KW)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .switch_output   (switch_output),
    .stall           (stall),
    .top_tuple       (top_tuple),
    .i_elems_0       (i_elems_0),
    .i_elems_1       (i_elems_1),
    .o_elems_0       (o_elems_0),
    .o_elems_1       (o_elems_1),
    .o_switch_output (o_switch_output),
    .o_stall         (o_stall),
    .o_top_tuple     (o_top_tuple)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- stimulus helpers ----------------
  function automatic logic [BEAT_W-1:0] mk_beat(input logic st, input logic sw,
                                                input logic [LW-1:0] top,
                                                input logic [LW-1:0] b,
                                                input logic [LW-1:0] a);
    return {st, sw, top, b, a};
  endfunction

  function automatic logic [LW-1:0] rand_wide();
    logic [LW-1:0] v;
    for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Ascending list with random payload; mode 1 draws keys from 0..7 to force ties.
  function automatic logic [LW-1:0] rand_list(input int mode);
    logic [KW-1:0] kq[$];
    logic [LW-1:0] v;
    logic [95:0]   r;
    logic [63:0]   r2;
    for (int i = 0; i < NH; i++) begin
      r = {$urandom, $urandom, $urandom};
      if (mode == 1) kq.push_back(KW'($urandom_range(0, 7)));
      else           kq.push_back(r[KW-1:0]);
    end
    kq.sort();
    for (int i = 0; i < NH; i++) begin
      r2 = {$urandom, $urandom};
      v[i*DW +: DW] = {r2[DW-KW-1:0], kq[i]};
    end
    return v;
  endfunction

  function automatic logic [BEAT_W-1:0] reset_beat();
    return mk_beat(1'b1, 1'b0, '0, '0, '0);
  endfunction

  task automatic drive(input logic [BEAT_W-1:0] b);
    i_elems_0     = b[0 +: LW];
    i_elems_1     = b[LW +: LW];
    top_tuple     = b[2*LW +: LW];
    switch_output = b[3*LW];
    stall         = b[3*LW + 1];
  endtask

  // ---------------- scoreboard ----------------
  // One clock per call: score the beat that entered LAT cycles ago, then drive a new one.
  task automatic sb_cycle(input logic [BEAT_W-1:0] beat, input bit release_rst);
    logic [BEAT_W-1:0] e;
    logic [LW-1:0]     etop;
    logic [KW-1:0]     kq[$];
    logic [DW-1:0]     iq[$];
    logic [DW-1:0]     oq[$];
    logic [DW-1:0]     rec;
    int                first;
    @(posedge i_clk);
    #1;
    if (exp_q.size() == LAT) begin
      e    = exp_q.pop_front();
      etop = e[2*LW +: LW];
      total++;
      if (o_stall !== e[3*LW + 1]) begin
        bad++;
        $display("FAIL sb_o_stall actual=%b required=%b", o_stall, e[3*LW + 1]);
      end
      total++;
      if (o_switch_output !== e[3*LW]) begin
        bad++;
        $display("FAIL sb_o_switch_output actual=%b required=%b", o_switch_output, e[3*LW]);
      end
      total++;
      if (o_top_tuple !== etop) begin
        bad++;
        first = 0;
        for (int w = LW / 32 - 1; w >= 0; w--)
          if (o_top_tuple[w*32 +: 32] !== etop[w*32 +: 32]) first = w;
        $display("FAIL sb_o_top_tuple word%0d actual=%h required=%h",
                 first, o_top_tuple[first*32 +: 32], etop[first*32 +: 32]);
      end
      for (int i = 0; i < NH; i++) begin
        kq.push_back(e[i*DW +: KW]);
        kq.push_back(e[LW + i*DW +: KW]);
        iq.push_back(e[i*DW +: DW]);
        iq.push_back(e[LW + i*DW +: DW]);
      end
      kq.sort();
      iq.sort();
      for (int p = 0; p < 2 * NH; p++) begin
        if (p < NH) rec = o_elems_0[p*DW +: DW];
        else        rec = o_elems_1[(p-NH)*DW +: DW];
        oq.push_back(rec);
        total++;
        if (rec[KW-1:0] !== kq[p]) begin
          bad++;
          $display("FAIL sb_key[%0d] actual=%h required=%h", p, rec[KW-1:0], kq[p]);
        end
      end
      oq.sort();
      first = -1;
      for (int p = 2 * NH - 1; p >= 0; p--)
        if (oq[p] !== iq[p]) first = p;
      total++;
      if (first >= 0) begin
        bad++;
        $display("FAIL sb_permutation sorted_rec[%0d] actual=%h required=%h",
                 first, oq[first], iq[first]);
      end
    end
    if (release_rst) i_rst_n = 1'b1;
    drive(beat);
    exp_q.push_back(beat);
  endtask

  task automatic drain();
    for (int i = 0; i < LAT; i++)
      sb_cycle(mk_beat(1'b1, 1'($urandom_range(0, 1)), rand_wide(), rand_list(0), rand_list(0)), 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    drive(mk_beat(1'b0, 1'b1, rand_wide(), rand_list(0), rand_list(0)));
    repeat (2) @(posedge i_clk);
    #1;
    total++;
    if (o_stall !== 1'b1) begin bad++; $display("FAIL reset_o_stall actual=%b required=1", o_stall); end
    total++;
    if (o_switch_output !== 1'b0) begin
      bad++; $display("FAIL reset_o_switch_output actual=%b required=0", o_switch_output);
    end
    total++;
    if (o_elems_0 !== '0) begin bad++; $display("FAIL reset_o_elems_0 actual_low=%h required=0", o_elems_0[63:0]); end
    total++;
    if (o_elems_1 !== '0) begin bad++; $display("FAIL reset_o_elems_1 actual_low=%h required=0", o_elems_1[63:0]); end
    total++;
    if (o_top_tuple !== '0) begin bad++; $display("FAIL reset_o_top_tuple actual_low=%h required=0", o_top_tuple[63:0]); end
    exp_q.delete();
    for (int i = 0; i < LAT; i++) exp_q.push_back(reset_beat());
    drive(reset_beat());
    i_rst_n = 1'b1;
  endtask

  task automatic test_interleave();
    logic [LW-1:0] a, b;
    for (int i = 0; i < NH; i++) begin
      a[i*DW +: DW] = {48'($urandom), KW'(2 * i)};
      b[i*DW +: DW] = {48'($urandom), KW'(2 * i + 1)};
    end
    sb_cycle(mk_beat(1'b0, 1'b0, rand_wide(), b, a), 1'b0);
  endtask

  task automatic test_disjoint();
    logic [LW-1:0] a, b;
    for (int i = 0; i < NH; i++) begin
      a[i*DW +: DW] = {48'($urandom), KW'(100 + i)};
      b[i*DW +: DW] = {48'($urandom), KW'(1 + i)};
    end
    sb_cycle(mk_beat(1'b0, 1'b1, rand_wide(), b, a), 1'b0);
    sb_cycle(mk_beat(1'b0, 1'b0, rand_wide(), a, b), 1'b0);
  endtask

  task automatic test_ties_payload();
    logic [LW-1:0] a, b;
    for (int i = 0; i < NH; i++) begin
      a[i*DW +: DW] = {48'(i), KW'(7)};
      b[i*DW +: DW] = {48'(NH + i), KW'(7)};
    end
    sb_cycle(mk_beat(1'b0, 1'b0, rand_wide(), b, a), 1'b0);
  endtask

  task automatic test_streaming_sideband();
    logic [3:0]    st_pat = 4'b0110;
    logic [3:0]    sw_pat = 4'b0101;
    logic [LW-1:0] top_a  = {(LW / 8){8'hA5}};
    logic [LW-1:0] top_b  = {(LW / 8){8'h5A}};
    for (int i = 0; i < 4; i++)
      sb_cycle(mk_beat(st_pat[i], sw_pat[i], (i % 2 == 0) ? top_a : top_b,
                       rand_list(0), rand_list(0)), 1'b0);
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 40; i++)
      sb_cycle(mk_beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_wide(),
                       rand_list(i % 2), rand_list((i / 2) % 2)), 1'b0);
  endtask

  task automatic test_mid_reset();
    for (int j = 0; j < 10; j++) begin
      if (j == 3) begin
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        total++;
        if (o_stall !== 1'b1) begin bad++; $display("FAIL midreset_o_stall actual=%b required=1", o_stall); end
        total++;
        if (o_switch_output !== 1'b0) begin
          bad++; $display("FAIL midreset_o_switch_output actual=%b required=0", o_switch_output);
        end
        total++;
        if ({o_elems_1, o_elems_0} !== '0) begin
          bad++; $display("FAIL midreset_o_elems actual_low=%h required=0", o_elems_0[63:0]);
        end
        total++;
        if (o_top_tuple !== '0) begin
          bad++; $display("FAIL midreset_o_top_tuple actual_low=%h required=0", o_top_tuple[63:0]);
        end
        exp_q.delete();
        for (int i = 0; i < LAT; i++) exp_q.push_back(reset_beat());
        drive(reset_beat());
      end else begin
        sb_cycle(mk_beat(1'b0, 1'($urandom_range(0, 1)), rand_wide(), rand_list(0), rand_list(0)),
                 (j == 4));
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_interleave();
    test_disjoint();
    test_ties_payload();
    test_streaming_sideband();
    test_back_to_back_random();
    drain();
    test_mid_reset();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
